// File: rtl/fetch_decode_unit.sv
// Single-issue fetch/decode control stage for the register-bank datapath.
// Optional fetch timeout guarded by IMEM_TIMEOUT_EN (fault tied 0 when undefined).
module fetch_decode_unit #(
  parameter int              PC_W          = 5,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  input  logic [4:0]      target,
  input  logic            cond_ok,
  output logic            alu_sum,
  output logic            wb,
  output logic            mem_wb,
  output logic            imm_wb,
  output logic            eq_in,
  output logic            lt_in,
  output logic            reset_st,
  output logic            set_st,
  output logic [4:0]      dest,
  output logic [4:0]      source1,
  output logic [4:0]      source2,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal,
  output logic            fault,
  output logic [15:0]     retired
);

  if (PC_W < 5 || FETCH_TIMEOUT < 1) begin : g_bad_params
    $error("fetch_decode_unit: PC_W must be >= 5 and FETCH_TIMEOUT >= 1");
  end

  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_CMP = 4'd3,
                         OP_CLR = 4'd4, OP_LDI = 4'd5, OP_STR = 4'd6, OP_BR  = 4'd7,
                         OP_HLT = 4'd8;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALTED} state_t;

  state_t     state, state_nxt;
  logic [3:0] op;
  logic       take;
  logic       to_hit;
  logic       unused;

  assign unused    = ^imem_data[10:0];
  // Gate with rst_n so the request drops the instant reset asserts.
  assign imem_req  = rst_n && (state == S_FETCH);
  assign imem_addr = pc;
  assign take      = (state == S_FETCH) && imem_ack;

`ifdef IMEM_TIMEOUT_EN
  localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt;

  // Counter sits at 0 outside FETCH, so entry to FETCH always starts clean.
  assign to_hit = (state == S_FETCH) && !imem_ack && (wait_cnt == TO_W'(FETCH_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            wait_cnt <= '0;
    else if (state != S_FETCH || imem_ack) wait_cnt <= '0;
    else                                   wait_cnt <= wait_cnt + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fault <= 1'b0;
    else if (to_hit) fault <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  assign fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (to_hit) state_nxt = S_HALTED;
                else if (imem_ack) state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (op == OP_HLT) ? S_HALTED : S_FETCH;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= OP_NOP;
      alu_sum  <= 1'b0;
      wb       <= 1'b0;
      mem_wb   <= 1'b0;
      imm_wb   <= 1'b0;
      eq_in    <= 1'b0;
      lt_in    <= 1'b0;
      reset_st <= 1'b0;
      set_st   <= 1'b0;
      dest     <= '0;
      source1  <= '0;
      source2  <= '0;
      pc       <= RESET_PC;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      retired  <= '0;
    end else begin
      // Strobes live for exactly the EXEC cycle; fields keep their last value.
      alu_sum  <= 1'b0;
      wb       <= 1'b0;
      mem_wb   <= 1'b0;
      imm_wb   <= 1'b0;
      eq_in    <= 1'b0;
      lt_in    <= 1'b0;
      reset_st <= 1'b0;
      set_st   <= 1'b0;
      if (take) begin
        op      <= imem_data[31:28];
        dest    <= imem_data[27:23];
        source1 <= imem_data[22:18];
        source2 <= imem_data[17:13];
        eq_in   <= imem_data[12];
        lt_in   <= imem_data[11];
        case (imem_data[31:28])
          OP_NOP, OP_HLT: ;
          OP_ADD: begin alu_sum <= 1'b1; wb <= 1'b1; end
          OP_SUB: wb <= 1'b1;
          OP_CMP: set_st <= 1'b1;
          OP_CLR: reset_st <= 1'b1;
          OP_LDI: imm_wb <= 1'b1;
          OP_STR: begin alu_sum <= 1'b1; mem_wb <= 1'b1; end
          OP_BR:  alu_sum <= 1'b1;
          default: illegal <= 1'b1;
        endcase
      end
      if (state == S_EXEC) begin
        if (retired != 16'hFFFF) retired <= retired + 16'd1;
        if (op == OP_HLT)                halted <= 1'b1;
        else if (op == OP_BR && cond_ok) pc     <= PC_W'(target);
        else                             pc     <= pc + PC_W'(1);
      end
      if (to_hit) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Randomized bench for fetch_decode_unit against an instruction-level reference model.
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [4:0]  target = '0;
  logic        cond_ok = 1'b0;
  logic        alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st;
  logic [4:0]  dest, source1, source2;
  logic [4:0]  pc;
  logic        halted, illegal, fault;
  logic [15:0] retired;
  logic [7:0]  strb;

  fetch_decode_unit #(.PC_W(5), .RESET_PC(5'd0), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .target(target), .cond_ok(cond_ok),
    .alu_sum(alu_sum), .wb(wb), .mem_wb(mem_wb), .imm_wb(imm_wb), .eq_in(eq_in),
    .lt_in(lt_in), .reset_st(reset_st), .set_st(set_st), .dest(dest),
    .source1(source1), .source2(source2), .pc(pc), .halted(halted),
    .illegal(illegal), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  assign strb = {alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st};

  int n_chk = 0, n_pass = 0;

  // Reference: instruction memory plus architectural state.
  logic [31:0] mem [32];
  logic [7:0]  lut [16];
  logic [4:0]  m_pc;
  logic [15:0] m_ret;
  logic        m_ill, m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic e, input logic l);
    logic [31:0] w;
    w = $urandom;
    w[31:28] = op;
    w[12] = e;
    w[11] = l;
    return w;
  endfunction

  function automatic logic [7:0] exp_strb(input logic [31:0] w);
    return lut[w[31:28]] | {4'b0, w[12], w[11], 2'b0};
  endfunction

  task automatic reset_dut;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_strb", strb, 0);
    chk("rst_flags", {halted, illegal, fault}, 0);
    chk("rst_ret", retired, 0);
    chk("rst_fields", {dest, source1, source2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_ret = 0; m_ill = 0; m_halt = 0;
  endtask

  // Fetch mem[m_pc] after `delay` idle cycles, execute it with the given datapath inputs.
  task automatic do_instr(input int delay, input logic [4:0] tgt, input logic cok);
    logic [31:0] w;
    w = mem[m_pc];
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("pc", pc, m_pc);
        chk("retired", retired, m_ret);
        chk("illegal", illegal, m_ill);
        chk("halted", halted, 0);
      end
      chk("req", imem_req, 1);
      chk("addr", imem_addr, m_pc);
      chk("wait_strb", strb, 0);
      imem_ack  = (i == delay);
      imem_data = (i == delay) ? w : $urandom;
    end
    @(posedge clk);
    #1;
    // Acks outside FETCH must be ignored.
    imem_ack  = $urandom;
    imem_data = $urandom;
    target    = tgt;
    cond_ok   = cok;
    @(negedge clk);
    chk("exec_strb", strb, exp_strb(w));
    chk("exec_fields", {dest, source1, source2}, {w[27:23], w[22:18], w[17:13]});
    chk("exec_req", imem_req, 0);
    if (m_ret != 16'hFFFF) m_ret++;
    if (w[31:28] >= 4'd9) m_ill = 1;
    if (w[31:28] == 4'd8) m_halt = 1;
    else if (w[31:28] == 4'd7 && cok) m_pc = tgt;
    else m_pc = m_pc + 5'd1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
  endtask

  task automatic chk_halted(input string tag);
    @(negedge clk);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_ret"}, retired, m_ret);
    chk({tag, "_strb"}, strb, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = 8'h00;
    lut[1] = 8'b1100_0000; lut[2] = 8'b0100_0000; lut[3] = 8'b0000_0001;
    lut[4] = 8'b0000_0010; lut[5] = 8'b0001_0000; lut[6] = 8'b1010_0000;
    lut[7] = 8'b1000_0000;

    reset_dut();

    // ADD, SUB, HALT with immediate acks.
    mem[0] = mk(4'd1, 0, 0); mem[1] = mk(4'd2, 0, 0); mem[2] = mk(4'd8, 0, 0);
    for (int i = 0; i < 3; i++) do_instr(0, 5'($urandom), 1'($urandom));
    chk_halted("halt");
    chk("halt_pc2", pc, 2);
    chk("halt_ret3", retired, 3);
    imem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halted_stay_req", imem_req, 0);
      chk("halted_stay_pc", pc, 2);
    end

    // Asynchronous reset while a fetch is outstanding.
    reset_dut();
    mem[0] = mk(4'd0, 0, 0);
    do_instr(0, 0, 0);
    @(negedge clk);
    chk("midfetch_req_before", imem_req, 1);
    #2;
    reset_dut();

    // CMP then BR at pc=4, taken and not taken.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) mem[i] = mk(4'd0, 1'($urandom), 1'($urandom));
      mem[3] = mk(4'd3, 0, 0);
      mem[4] = mk(4'd7, 1, 0);
      for (int i = 0; i < 4; i++) do_instr(0, 5'($urandom), 1'($urandom));
      do_instr(0, 5'h10, (k == 0));
      @(negedge clk);
      chk(k == 0 ? "br_taken_pc" : "br_not_taken_pc", pc, k == 0 ? 32'h10 : 32'h5);
      reset_dut();
    end

    // Undefined opcode behaves as NOP and sets a sticky flag.
    mem[0] = mk(4'hC, 0, 0); mem[1] = mk(4'd1, 0, 0); mem[2] = mk(4'd0, 0, 0);
    do_instr(0, 0, 1);
    @(negedge clk);
    chk("illegal_set", illegal, 1);
    chk("illegal_pc1", pc, 1);
    do_instr(0, 0, 1);
    do_instr(1, 0, 1);
    @(negedge clk);
    chk("illegal_sticky", illegal, 1);
    reset_dut();

    // PC wrap from 31.
    mem[0] = mk(4'd7, 0, 0); mem[31] = mk(4'd0, 0, 0);
    do_instr(0, 5'd31, 1);
    do_instr(1, 0, 0);
    @(negedge clk);
    chk("wrap_pc", pc, 0);
    reset_dut();

    // Three wait cycles on every fetch.
    for (int i = 0; i < 6; i++) mem[i] = mk(4'($urandom_range(0, 6)), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 6; i++) do_instr(3, 5'($urandom_range(0, 5)), 1'($urandom));
    reset_dut();

    // Random programs with random wait states and branch outcomes.
    for (int i = 0; i < 32; i++) begin
      logic [3:0] op;
      op = 4'($urandom);
      if (op == 4'd8) op = 4'd7;
      mem[i] = mk(op, 1'($urandom), 1'($urandom));
    end
    mem[$urandom_range(10, 31)] = mk(4'd8, 0, 0);
    for (int n = 0; n < 250 && !m_halt; n++)
      do_instr($urandom_range(0, 3), 5'($urandom), 1'($urandom));
    if (m_halt) chk_halted("rand_halt");
    else begin
      @(negedge clk);
      chk("rand_pc", pc, m_pc);
      chk("rand_ret", retired, m_ret);
    end
    chk("fault_clear", fault, 0);
    reset_dut();

`ifdef IMEM_TIMEOUT_EN
    imem_ack = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("to_fault_early", fault, 0);
    chk("to_req_early", imem_req, 1);
    @(negedge clk);
    chk("to_fault", fault, 1);
    chk("to_halted", halted, 1);
    chk("to_req", imem_req, 0);
    chk("to_ret", retired, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
